vga_timing_gen: RTL and testbench

//  Pixel-clock-domain VGA raster generator; consumes the 25 MHz pixel clock and PLL lock flag from the VGA PLL.

---
 rtl/vga_timing_gen.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------------------------
// vga_timing_gen
//   VGA raster generator running in the pixel-clock domain. Waits for a stable PLL lock, then
//   scans the raster, issues pixel-coordinate requests to the frame-buffer reader, and re-aligns
//   the returned RGB with the sync/blank signals before driving the DAC pins.
//   Loss of lock drops back to the idle state; the raster restarts at the frame origin.
//
// Optional feature (compile-time macro):
//   VGA_TEST_PATTERN_EN - when defined, test_pat=1 replaces the pixel data with eight vertical
//                         colour bars; when undefined, test_pat is ignored.
//
// Ports:
//   clk          pixel clock
//   rst          synchronous reset, active-high
//   pll_locked   PLL lock flag (asynchronous, synchronised internally)
//   req_valid    pixel request this cycle (active area)
//   req_x/req_y  requested column/row (zero when req_valid=0)
//   pix_r/g/b    pixel data, valid PIPE_DLY cycles after the request
//   test_pat     colour-bar select (only with VGA_TEST_PATTERN_EN)
//   vga_r/g/b    DAC colour, zero while blanked
//   vga_hs/vs    sync outputs, active level given by HS_POL/VS_POL
//   vga_blank_n  high during active video
//   frame_start  one-cycle pulse at h=0,v=0 (request timebase)
//   running      raster active
// ---------------------------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter bit          HS_POL    = 1'b0,
    parameter bit          VS_POL    = 1'b0,
    parameter int unsigned LOCK_WAIT = 16,
    parameter int unsigned PIPE_DLY  = 2,
    parameter int unsigned COLOR_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pll_locked,
    output logic               req_valid,
    output logic [9:0]         req_x,
    output logic [9:0]         req_y,
    input  logic [COLOR_W-1:0] pix_r,
    input  logic [COLOR_W-1:0] pix_g,
    input  logic [COLOR_W-1:0] pix_b,
    input  logic               test_pat,
    output logic [COLOR_W-1:0] vga_r,
    output logic [COLOR_W-1:0] vga_g,
    output logic [COLOR_W-1:0] vga_b,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               vga_blank_n,
    output logic               frame_start,
    output logic               running
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned LockW   = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;

    // 11-bit window bounds so the sync end never wraps even with H_TOTAL=1024
    localparam logic [10:0] HActEnd   = 11'(H_ACTIVE);
    localparam logic [10:0] HSyncBeg  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HSyncEnd  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VActEnd   = 11'(V_ACTIVE);
    localparam logic [10:0] VSyncBeg  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VSyncEnd  = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  HLast     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  VLast     = 10'(V_TOTAL - 1);
    localparam logic [LockW-1:0] LockLast = LockW'(LOCK_WAIT - 1);

    // Elaboration-time parameter checks
    if (H_TOTAL > 1024) begin : g_chk_h_total
        $error("vga_timing_gen: H_TOTAL must not exceed 1024");
    end
    if (V_TOTAL > 1024) begin : g_chk_v_total
        $error("vga_timing_gen: V_TOTAL must not exceed 1024");
    end
    if (LOCK_WAIT < 1) begin : g_chk_lock_wait
        $error("vga_timing_gen: LOCK_WAIT must be at least 1");
    end
    if (PIPE_DLY < 1 || PIPE_DLY > 8) begin : g_chk_pipe_dly
        $error("vga_timing_gen: PIPE_DLY must be in 1..8");
    end

    // -----------------------------------------------------------------------------------------
    // Lock synchroniser
    // -----------------------------------------------------------------------------------------
    logic lk_meta_q;
    logic lk_s_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lk_meta_q <= 1'b0;
            lk_s_q    <= 1'b0;
        end else begin
            lk_meta_q <= pll_locked;
            lk_s_q    <= lk_meta_q;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Control FSM and raster counters
    // -----------------------------------------------------------------------------------------
    typedef enum logic [0:0] {StWaitLock, StRun} state_e;

    state_e           state_q, state_d;
    logic [LockW-1:0] lock_cnt_q, lock_cnt_d;
    logic [9:0]       h_cnt_q, h_cnt_d;
    logic [9:0]       v_cnt_q, v_cnt_d;
    logic             pipe_clr;

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        h_cnt_d    = h_cnt_q;
        v_cnt_d    = v_cnt_q;
        pipe_clr   = 1'b0;
        unique case (state_q)
            StWaitLock: begin
                h_cnt_d = '0;
                v_cnt_d = '0;
                if (!lk_s_q) begin
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == LockLast) begin
                    state_d    = StRun;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + LockW'(1);
                end
            end
            StRun: begin
                lock_cnt_d = '0;
                if (!lk_s_q) begin
                    // Abandon the frame: no partial frame is ever emitted after relock
                    state_d  = StWaitLock;
                    h_cnt_d  = '0;
                    v_cnt_d  = '0;
                    pipe_clr = 1'b1;
                end else if (h_cnt_q == HLast) begin
                    h_cnt_d = '0;
                    v_cnt_d = (v_cnt_q == VLast) ? 10'd0 : v_cnt_q + 10'd1;
                end else begin
                    h_cnt_d = h_cnt_q + 10'd1;
                end
            end
            default: begin
                state_d = StWaitLock;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StWaitLock;
            lock_cnt_q <= '0;
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Stage 0: request generation and raw timing, combinational from the counters
    // -----------------------------------------------------------------------------------------
    logic        run;
    logic [10:0] h_ext;
    logic [10:0] v_ext;
    logic        de;
    logic        hs_raw;
    logic        vs_raw;

    assign run    = (state_q == StRun);
    assign h_ext  = {1'b0, h_cnt_q};
    assign v_ext  = {1'b0, v_cnt_q};
    assign de     = run && (h_ext < HActEnd) && (v_ext < VActEnd);
    assign hs_raw = run && (h_ext >= HSyncBeg) && (h_ext < HSyncEnd);
    assign vs_raw = run && (v_ext >= VSyncBeg) && (v_ext < VSyncEnd);

    assign req_valid   = de;
    assign req_x       = de ? h_cnt_q : 10'd0;
    assign req_y       = de ? v_cnt_q : 10'd0;
    assign frame_start = run && (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
    assign running     = run;

    // -----------------------------------------------------------------------------------------
    // Timing delay line: matches the frame-buffer read latency so sync/blank line up with pix
    // -----------------------------------------------------------------------------------------
    logic [PIPE_DLY-1:0] de_sr_q;
    logic [PIPE_DLY-1:0] hs_sr_q;
    logic [PIPE_DLY-1:0] vs_sr_q;

    always_ff @(posedge clk) begin
        if (rst || pipe_clr) begin
            de_sr_q <= '0;
            hs_sr_q <= '0;
            vs_sr_q <= '0;
        end else begin
            de_sr_q[0] <= de;
            hs_sr_q[0] <= hs_raw;
            vs_sr_q[0] <= vs_raw;
            for (int i = 1; i < PIPE_DLY; i++) begin
                de_sr_q[i] <= de_sr_q[i-1];
                hs_sr_q[i] <= hs_sr_q[i-1];
                vs_sr_q[i] <= vs_sr_q[i-1];
            end
        end
    end

    logic de_d;
    logic hs_d;
    logic vs_d;

    assign de_d = de_sr_q[PIPE_DLY-1];
    assign hs_d = hs_sr_q[PIPE_DLY-1];
    assign vs_d = vs_sr_q[PIPE_DLY-1];

`ifdef VGA_TEST_PATTERN_EN
    // -----------------------------------------------------------------------------------------
    // Colour-bar index, carried through the same delay as the timing so bars align with sync
    // -----------------------------------------------------------------------------------------
    logic [2:0] bar_idx;
    logic [2:0] bar_sr_q [PIPE_DLY];
    logic [2:0] bar_d;

    assign bar_idx = de ? 3'((32'(h_cnt_q) * 32'd8) / H_ACTIVE) : 3'd0;

    always_ff @(posedge clk) begin
        if (rst || pipe_clr) begin
            for (int i = 0; i < PIPE_DLY; i++) begin
                bar_sr_q[i] <= '0;
            end
        end else begin
            bar_sr_q[0] <= bar_idx;
            for (int i = 1; i < PIPE_DLY; i++) begin
                bar_sr_q[i] <= bar_sr_q[i-1];
            end
        end
    end

    assign bar_d = bar_sr_q[PIPE_DLY-1];
`else
    logic unused_test_pat;
    assign unused_test_pat = test_pat;
`endif

    // -----------------------------------------------------------------------------------------
    // Output stage
    // -----------------------------------------------------------------------------------------
    logic [COLOR_W-1:0] r_d, g_d, b_d;

    always_comb begin
        r_d = '0;
        g_d = '0;
        b_d = '0;
        // Pixel inputs are only looked at inside the active window
        if (de_d) begin
            r_d = pix_r;
            g_d = pix_g;
            b_d = pix_b;
`ifdef VGA_TEST_PATTERN_EN
            if (test_pat) begin
                r_d = {COLOR_W{bar_d[2]}};
                g_d = {COLOR_W{bar_d[1]}};
                b_d = {COLOR_W{bar_d[0]}};
            end
`endif
        end
    end

    logic [COLOR_W-1:0] vga_r_q, vga_g_q, vga_b_q;
    logic               vga_hs_q, vga_vs_q, vga_blank_n_q;

    always_ff @(posedge clk) begin
        if (rst || pipe_clr) begin
            vga_r_q       <= '0;
            vga_g_q       <= '0;
            vga_b_q       <= '0;
            vga_hs_q      <= ~HS_POL;
            vga_vs_q      <= ~VS_POL;
            vga_blank_n_q <= 1'b0;
        end else begin
            vga_r_q       <= r_d;
            vga_g_q       <= g_d;
            vga_b_q       <= b_d;
            vga_hs_q      <= hs_d ? HS_POL : ~HS_POL;
            vga_vs_q      <= vs_d ? VS_POL : ~VS_POL;
            vga_blank_n_q <= de_d;
        end
    end

    assign vga_r       = vga_r_q;
    assign vga_g       = vga_g_q;
    assign vga_b       = vga_b_q;
    assign vga_hs      = vga_hs_q;
    assign vga_vs      = vga_vs_q;
    assign vga_blank_n = vga_blank_n_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------------------------
// tb_vga_timing_gen
//   Self-checking bench for vga_timing_gen with a shrunken raster (25 x 11) so whole frames fit
//   in a short run. A bench-side raster model predicts requests each cycle and pushes the
//   expected pin values into a queue; the pins are compared when the entry pops out PIPE_DLY+1
//   cycles later. A frame-buffer model answers requests with {x, y, 8'h5A} after PIPE_DLY
//   cycles and drives random data outside the active window.
// ---------------------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_timing_gen;

    localparam int unsigned HA  = 16;
    localparam int unsigned HF  = 2;
    localparam int unsigned HSY = 4;
    localparam int unsigned HB  = 3;
    localparam int unsigned VA  = 6;
    localparam int unsigned VF  = 1;
    localparam int unsigned VSY = 2;
    localparam int unsigned VB  = 2;
    localparam int unsigned HT  = HA + HF + HSY + HB;
    localparam int unsigned VT  = VA + VF + VSY + VB;
    localparam int unsigned LW  = 16;
    localparam int unsigned PD  = 2;

`ifdef VGA_TEST_PATTERN_EN
    localparam bit PatEn = 1'b1;
`else
    localparam bit PatEn = 1'b0;
`endif

    localparam logic [26:0] RstPins = {24'h0, 1'b1, 1'b1, 1'b0};

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       test_pat;
    logic       req_valid;
    logic [9:0] req_x, req_y;
    logic [7:0] pix_r, pix_g, pix_b;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, vga_blank_n, frame_start, running;

    always #20 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE  (HA),
        .H_FP      (HF),
        .H_SYNC    (HSY),
        .H_BP      (HB),
        .V_ACTIVE  (VA),
        .V_FP      (VF),
        .V_SYNC    (VSY),
        .V_BP      (VB),
        .HS_POL    (1'b0),
        .VS_POL    (1'b0),
        .LOCK_WAIT (LW),
        .PIPE_DLY  (PD),
        .COLOR_W   (8)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .req_valid   (req_valid),
        .req_x       (req_x),
        .req_y       (req_y),
        .pix_r       (pix_r),
        .pix_g       (pix_g),
        .pix_b       (pix_b),
        .test_pat    (test_pat),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_blank_n (vga_blank_n),
        .frame_start (frame_start),
        .running     (running)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Bench raster model
    bit          m_run      = 1'b0;
    int          mh         = 0;
    int          mv         = 0;
    bit          start_pend = 1'b0;
    bit          stop_pend  = 1'b0;
    int          cyc        = 0;
    int          last_fs    = -1;
    logic [26:0] pin_q[$];
    logic [20:0] fb1        = '0;
    logic [20:0] fb2        = '0;

    function automatic logic [26:0] exp_pins(input bit run, input int h, input int v,
                                             input bit tp);
        logic [7:0] r, g, b;
        logic       hs, vs, de;
        int         idx;
        r = 8'h0;
        g = 8'h0;
        b = 8'h0;
        if (!run) return RstPins;
        de = (h < HA) && (v < VA);
        hs = (h >= HA + HF && h < HA + HF + HSY) ? 1'b0 : 1'b1;
        vs = (v >= VA + VF && v < VA + VF + VSY) ? 1'b0 : 1'b1;
        if (de) begin
            r = 8'(h);
            g = 8'(v);
            b = 8'h5A;
            if (PatEn && tp) begin
                idx = h * 8 / HA;
                r = idx[2] ? 8'hFF : 8'h00;
                g = idx[1] ? 8'hFF : 8'h00;
                b = idx[0] ? 8'hFF : 8'h00;
            end
        end
        return {r, g, b, hs, vs, de};
    endfunction

    task automatic step();
        logic        ev;
        logic [22:0] exp_req;
        logic [26:0] e;
        @(posedge clk);
        #1;
        cyc++;
        if (start_pend) begin
            m_run      = 1'b1;
            mh         = 0;
            mv         = 0;
            start_pend = 1'b0;
            last_fs    = -1;
        end else if (stop_pend) begin
            m_run     = 1'b0;
            mh        = 0;
            mv        = 0;
            stop_pend = 1'b0;
            last_fs   = -1;
            pin_q.delete();
            repeat (PD + 1) pin_q.push_back(RstPins);
        end else if (m_run) begin
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh++;
            end
        end

        // Frame buffer answers the request issued PD cycles ago
        if (fb2[20]) begin
            pix_r = fb2[17:10];
            pix_g = fb2[7:0];
            pix_b = 8'h5A;
        end else begin
            pix_r = 8'($urandom);
            pix_g = 8'($urandom);
            pix_b = 8'($urandom);
        end
        fb2 = fb1;
        fb1 = {req_valid, req_x, req_y};

        ev      = m_run && (mh < HA) && (mv < VA);
        exp_req = {m_run, m_run && mh == 0 && mv == 0, ev,
                   ev ? 10'(mh) : 10'd0, ev ? 10'(mv) : 10'd0};
        check_eq("req", 64'({running, frame_start, req_valid, req_x, req_y}), 64'(exp_req));

        pin_q.push_back(exp_pins(m_run, mh, mv, test_pat));
        e = pin_q.pop_front();
        check_eq("pins", 64'({vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n}), 64'(e));

        if (frame_start) begin
            if (last_fs >= 0) check_eq("frame_len", 64'(cyc - last_fs), 64'(HT * VT));
            last_fs = cyc;
        end
    endtask

    // Steps through lock qualification, arming the model for the cycle RUN should start
    task automatic qualify(input string tag);
        int lat;
        lat = -1;
        for (int i = 1; i <= int'(LW) + 2; i++) begin
            if (i == int'(LW) + 2) start_pend = 1'b1;
            step();
            if (running && lat < 0) lat = i;
        end
        check_eq(tag, 64'(lat), 64'(LW + 2));
    endtask

    task automatic drop_lock();
        pll_locked = 1'b0;
        step();
        step();
        stop_pend = 1'b1;
        step();
    endtask

    initial begin
        rst        = 1'b1;
        pll_locked = 1'b0;
        test_pat   = 1'b0;
        pix_r      = 8'h0;
        pix_g      = 8'h0;
        pix_b      = 8'h0;
        stop_pend  = 1'b1;
        repeat (4) step();
        rst = 1'b0;
        repeat (3) step();
        check_eq("idle_pins", 64'({vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n}),
                 64'(RstPins));
        check_eq("idle_running", 64'(running), 64'(0));

        // T1: lock qualification latency, first request at the frame origin
        pll_locked = 1'b1;
        qualify("t1_lock_lat");
        check_eq("t1_frame_start", 64'(frame_start), 64'(1));

        // T3/T4: two full frames with per-cycle pin checks
        repeat (2 * HT * VT) step();

        // T5: lock loss mid-line, then relock restarts at the origin
        for (int i = 0; i < int'(HT * VT) && !(mh == 10 && mv == 3); i++) step();
        check_eq("t5_at_pos", 64'({req_x, req_y}), 64'({10'd10, 10'd3}));
        drop_lock();
        check_eq("t5_req_valid", 64'(req_valid), 64'(0));
        check_eq("t5_blank_n", 64'(vga_blank_n), 64'(0));
        repeat (4) step();
        pll_locked = 1'b1;
        qualify("t5_relock_lat");
        check_eq("t5_origin", 64'({frame_start, req_x, req_y}), 64'({1'b1, 20'd0}));
        repeat (HT * 4 + 7) step();

        // Reset mid-frame with lock held: qualification restarts
        rst       = 1'b1;
        stop_pend = 1'b1;
        step();
        rst = 1'b0;
        qualify("rst_requal_lat");
        repeat (HT * 2) step();

        // T2: one-cycle lock glitch restarts the qualification count
        drop_lock();
        test_pat = 1'b1;
        repeat (3) step();
        pll_locked = 1'b1;
        repeat (10) step();
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        qualify("t2_glitch_lat");

        // T6: one frame with test_pat=1 (bars when enabled, pix passthrough otherwise)
        repeat (HT * VT + 5) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
